// File: rtl/frame_head_seq.sv
// ---------------------------------------------------------------------------
// frame_head_seq
//
// Emits the header byte stream for each outgoing frame:
//   sync code -> frame counter -> optional reserved byte -> zero padding
// and keeps the running 48-bit frame counter that advances by a
// configurable step once per frame.
//
// Optional feature (compile-time macro FRAME_HEAD_CHK_EN):
//   appends one check byte (XOR of all earlier header bytes) after the
//   padding; hd_last then marks that check byte.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   sync_code_length    number of sync bytes (clamped to SYNC_MAX)
//   sync_code_content   sync bytes, right-aligned, first byte most significant
//   cntr_length         number of counter bytes (clamped to CNTR_MAX)
//   cntr_init           counter reload value
//   cntr_step           counter increment per frame
//   res_flag            emit the reserved byte when 1
//   res_content         reserved byte value
//   framehead_len       minimum header length; short headers are zero-padded
//   cfg_load            one-cycle pulse: reload the counter from cntr_init
//   frame_req           level request for one header
//   frame_ack           one-cycle pulse: request accepted, config snapshotted
//   hd_data/hd_valid/hd_ready/hd_last  header byte stream
//   head_done           one-cycle pulse after the last header byte
//   frame_cnt           current counter value
// ---------------------------------------------------------------------------
module frame_head_seq #(
  parameter int SYNC_MAX = 10,
  parameter int CNTR_MAX = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            sync_code_length,
  input  logic [8*SYNC_MAX-1:0] sync_code_content,
  input  logic [3:0]            cntr_length,
  input  logic [8*CNTR_MAX-1:0] cntr_init,
  input  logic [7:0]            cntr_step,
  input  logic                  res_flag,
  input  logic [7:0]            res_content,
  input  logic [7:0]            framehead_len,
  input  logic                  cfg_load,
  input  logic                  frame_req,
  output logic                  frame_ack,
  output logic [7:0]            hd_data,
  output logic                  hd_valid,
  input  logic                  hd_ready,
  output logic                  hd_last,
  output logic                  head_done,
  output logic [47:0]           frame_cnt
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_CNTR = 3'd2;
  localparam logic [2:0] ST_RES  = 3'd3;
  localparam logic [2:0] ST_PAD  = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;
`ifdef FRAME_HEAD_CHK_EN
  localparam logic [2:0] ST_CHK  = 3'd6;
`endif

  localparam logic [3:0] SYNC_MAX_L = 4'(SYNC_MAX);
  localparam logic [3:0] CNTR_MAX_L = 4'(CNTR_MAX);

  // Phase that follows 'ph', skipping phases of zero length.
  // From ST_IDLE it yields the first phase of a new header.
  function automatic logic [2:0] next_after(
    input logic [2:0] ph,
    input logic [3:0] ls,
    input logic [3:0] lc,
    input logic       lr,
    input logic [7:0] lp
  );
    logic [2:0] a_pad, a_res, a_cntr, a_sync, res;
`ifdef FRAME_HEAD_CHK_EN
    a_pad  = ST_CHK;
`else
    a_pad  = ST_FIN;
`endif
    a_res  = (lp != 8'd0) ? ST_PAD  : a_pad;
    a_cntr = lr           ? ST_RES  : a_res;
    a_sync = (lc != 4'd0) ? ST_CNTR : a_cntr;
    case (ph)
      ST_IDLE: res = (ls != 4'd0) ? ST_SYNC : a_sync;
      ST_SYNC: res = a_sync;
      ST_CNTR: res = a_cntr;
      ST_RES:  res = a_res;
      ST_PAD:  res = a_pad;
      default: res = ST_FIN;
    endcase
    return res;
  endfunction

  logic [2:0]            state;
  logic [7:0]            idx;
  logic [47:0]           cntr;
  logic                  pending;
  logic [7:0]            chk_acc;

  // per-frame snapshot
  logic [8*SYNC_MAX-1:0] sync_s;
  logic [3:0]            ls_s;
  logic [3:0]            lc_s;
  logic                  lr_s;
  logic [7:0]            res_s;
  logic [7:0]            lp_s;
  logic [7:0]            step_s;
  logic [47:0]           cnt_s;

  // lengths derived from the live config inputs (used at accept)
  logic [3:0]            ls_in;
  logic [3:0]            lc_in;
  logic [7:0]            lf_in;
  logic [7:0]            lp_in;
  logic [2:0]            first_phase;

  logic [3:0]            sh_s;
  logic [3:0]            sh_c;
  logic [7:0]            cur_len;
  logic [7:0]            cur_byte;
  logic                  in_phase;
  logic                  last_in_phase;
  logic [2:0]            nxt_phase;
  logic                  xfer;

  always_comb begin
    ls_in       = (sync_code_length > SYNC_MAX_L) ? SYNC_MAX_L : sync_code_length;
    lc_in       = (cntr_length > CNTR_MAX_L) ? CNTR_MAX_L : cntr_length;
    lf_in       = {4'b0, ls_in} + {4'b0, lc_in} + {7'b0, res_flag};
    lp_in       = (framehead_len > lf_in) ? (framehead_len - lf_in) : 8'd0;
    first_phase = next_after(ST_IDLE, ls_in, lc_in, res_flag, lp_in);
  end

  // Current byte is a pure function of (state, idx, snapshot), so it
  // holds naturally while hd_ready is low.
  always_comb begin
    sh_s     = ls_s - idx[3:0] - 4'd1;
    sh_c     = lc_s - idx[3:0] - 4'd1;
    cur_len  = 8'd0;
    cur_byte = 8'h00;
    in_phase = 1'b0;
    case (state)
      ST_SYNC: begin
        in_phase = 1'b1;
        cur_len  = {4'b0, ls_s};
        cur_byte = 8'(sync_s >> {sh_s, 3'b000});
      end
      ST_CNTR: begin
        in_phase = 1'b1;
        cur_len  = {4'b0, lc_s};
        cur_byte = 8'(cnt_s >> {sh_c, 3'b000});
      end
      ST_RES: begin
        in_phase = 1'b1;
        cur_len  = 8'd1;
        cur_byte = res_s;
      end
      ST_PAD: begin
        in_phase = 1'b1;
        cur_len  = lp_s;
        cur_byte = 8'h00;
      end
`ifdef FRAME_HEAD_CHK_EN
      ST_CHK: begin
        in_phase = 1'b1;
        cur_len  = 8'd1;
        cur_byte = chk_acc;
      end
`endif
      default: begin
        in_phase = 1'b0;
      end
    endcase
  end

  assign nxt_phase     = next_after(state, ls_s, lc_s, lr_s, lp_s);
  assign last_in_phase = (idx == cur_len - 8'd1);

  // The ack cycle masks both the stream and head_done, so hd_valid (or
  // head_done for an empty header) appears one cycle after frame_ack.
  assign hd_valid  = in_phase && !frame_ack;
  assign hd_data   = hd_valid ? cur_byte : 8'h00;
  assign hd_last   = hd_valid && last_in_phase && (nxt_phase == ST_FIN);
  assign head_done = (state == ST_FIN) && !frame_ack;
  assign frame_cnt = cntr;
  assign xfer      = hd_valid && hd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cntr      <= '0;
      pending   <= 1'b0;
      chk_acc   <= '0;
      frame_ack <= 1'b0;
      sync_s    <= '0;
      ls_s      <= '0;
      lc_s      <= '0;
      lr_s      <= 1'b0;
      res_s     <= '0;
      lp_s      <= '0;
      step_s    <= '0;
      cnt_s     <= '0;
    end else begin
      frame_ack <= 1'b0;
      if (cfg_load && (state != ST_IDLE)) begin
        pending <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (frame_req) begin
            sync_s    <= sync_code_content;
            ls_s      <= ls_in;
            lc_s      <= lc_in;
            lr_s      <= res_flag;
            res_s     <= res_content;
            lp_s      <= lp_in;
            step_s    <= cntr_step;
            cnt_s     <= cntr;
            idx       <= '0;
            chk_acc   <= '0;
            frame_ack <= 1'b1;
            state     <= first_phase;
            // a reload arriving with the request applies after this frame
            if (cfg_load) begin
              pending <= 1'b1;
            end
          end else if (cfg_load) begin
            cntr <= 48'(cntr_init);
          end
        end
        ST_FIN: begin
          if (!frame_ack) begin
            if (pending || cfg_load) begin
              cntr <= 48'(cntr_init);
            end else begin
              cntr <= cntr + {40'b0, step_s};
            end
            pending <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          if (xfer) begin
            chk_acc <= chk_acc ^ cur_byte;
            if (last_in_phase) begin
              state <= nxt_phase;
              idx   <= '0;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_head_seq.sv
// ---------------------------------------------------------------------------
// tb_frame_head_seq
//
// Directed and randomized header sequences checked against a byte-queue
// reference model built from the header rules (sync, counter, reserved,
// padding, optional XOR check byte) and a shadow frame counter.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_frame_head_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  sync_code_length;
  logic [79:0] sync_code_content;
  logic [3:0]  cntr_length;
  logic [47:0] cntr_init;
  logic [7:0]  cntr_step;
  logic        res_flag;
  logic [7:0]  res_content;
  logic [7:0]  framehead_len;
  logic        cfg_load;
  logic        frame_req;
  logic        frame_ack;
  logic [7:0]  hd_data;
  logic        hd_valid;
  logic        hd_ready;
  logic        hd_last;
  logic        head_done;
  logic [47:0] frame_cnt;

  int          n_asserts = 0;
  int          n_fail    = 0;

  logic [47:0] mcnt;
  bit          mpend;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  frame_head_seq #(
    .SYNC_MAX(10),
    .CNTR_MAX(6)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sync_code_length (sync_code_length),
    .sync_code_content(sync_code_content),
    .cntr_length      (cntr_length),
    .cntr_init        (cntr_init),
    .cntr_step        (cntr_step),
    .res_flag         (res_flag),
    .res_content      (res_content),
    .framehead_len    (framehead_len),
    .cfg_load         (cfg_load),
    .frame_req        (frame_req),
    .frame_ack        (frame_ack),
    .hd_data          (hd_data),
    .hd_valid         (hd_valid),
    .hd_ready         (hd_ready),
    .hd_last          (hd_last),
    .head_done        (head_done),
    .frame_cnt        (frame_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference header for the current inputs and shadow counter.
  task automatic build_exp();
    int ls, lc, lr, tot;
    logic [7:0] x;
    exp_q.delete();
    ls = (int'(sync_code_length) > 10) ? 10 : int'(sync_code_length);
    lc = (int'(cntr_length) > 6) ? 6 : int'(cntr_length);
    lr = int'(res_flag);
    for (int i = 0; i < ls; i++)
      exp_q.push_back(8'(sync_code_content >> (8 * (ls - 1 - i))));
    for (int j = 0; j < lc; j++)
      exp_q.push_back(8'(mcnt >> (8 * (lc - 1 - j))));
    if (lr == 1) exp_q.push_back(res_content);
    tot = ls + lc + lr;
    while (tot < int'(framehead_len)) begin
      exp_q.push_back(8'h00);
      tot++;
    end
`ifdef FRAME_HEAD_CHK_EN
    x = 8'h00;
    foreach (exp_q[k]) x = x ^ exp_q[k];
    exp_q.push_back(x);
`else
    x = 8'h00;
`endif
  endtask

  task automatic set_cfg(input logic [3:0] sl, input logic [79:0] sc, input logic [3:0] cl,
                         input logic [47:0] ci, input logic [7:0] st, input logic rf,
                         input logic [7:0] rc, input logic [7:0] fl);
    sync_code_length  = sl;
    sync_code_content = sc;
    cntr_length       = cl;
    cntr_init         = ci;
    cntr_step         = st;
    res_flag          = rf;
    res_content       = rc;
    framehead_len     = fl;
  endtask

  // Pulse cfg_load while idle: counter takes cntr_init.
  task automatic load_cfg();
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    mcnt = cntr_init;
    chk("cfg_load_cnt", 64'(frame_cnt), 64'(mcnt));
  endtask

  // One header. mode: 0 ready high, 1 toggling, 2 random.
  // load_at: loop cycle at which cfg_load pulses mid-frame (-1 none).
  // load_with_req: cfg_load together with frame_req.
  task automatic run_frame(input int mode, input int load_at, input bit load_with_req);
    int   n, k, cyc;
    bit   stalled, done_seen, r;
    logic [7:0] held_d;
    logic held_l;
    build_exp();
    n = exp_q.size();
    frame_req = 1'b1;
    cfg_load  = load_with_req;
    @(negedge clk);
    frame_req = 1'b0;
    cfg_load  = 1'b0;
    if (load_with_req) mpend = 1'b1;
    chk("frame_ack", 64'(frame_ack), 64'd1);
    chk("valid_during_ack", 64'(hd_valid), 64'd0);
    k = 0; cyc = 0; stalled = 0; done_seen = 0; held_d = '0; held_l = 1'b0;
    while (!done_seen && cyc < 800) begin
      if (stalled) begin
        chk("stall_valid", 64'(hd_valid), 64'd1);
        chk("stall_data", 64'(hd_data), 64'(held_d));
        chk("stall_last", 64'(hd_last), 64'(held_l));
      end
      if (head_done) begin
        done_seen = 1;
        chk("byte_count", 64'(k), 64'(n));
        chk("valid_at_done", 64'(hd_valid), 64'd0);
      end else begin
        case (mode)
          0:       r = 1;
          1:       r = cyc[0];
          default: r = ($urandom_range(0, 2) != 0);
        endcase
        stalled = 0;
        if (hd_valid) begin
          if (r) begin
            if (k < n) begin
              chk("hd_data", 64'(hd_data), 64'(exp_q[k]));
              chk("hd_last", 64'(hd_last), 64'(k == n - 1));
            end else begin
              chk("extra_byte", 64'(k), 64'(n));
            end
            k++;
          end else begin
            stalled = 1;
            held_d  = hd_data;
            held_l  = hd_last;
          end
        end
        hd_ready = r;
        if (cyc == load_at) begin
          cfg_load = 1'b1;
          mpend    = 1'b1;
        end
        @(negedge clk);
        cfg_load = 1'b0;
        cyc++;
      end
    end
    if (!done_seen) chk("head_done_timeout", 64'd0, 64'd1);
    mcnt  = mpend ? cntr_init : (mcnt + {40'b0, cntr_step});
    mpend = 1'b0;
    hd_ready = 1'b1;
    @(negedge clk);
    chk("head_done_pulse", 64'(head_done), 64'd0);
    chk("frame_cnt", 64'(frame_cnt), 64'(mcnt));
  endtask

  initial begin
    reset_n   = 1'b0;
    cfg_load  = 1'b0;
    frame_req = 1'b0;
    hd_ready  = 1'b1;
    mcnt      = '0;
    mpend     = 1'b0;
    set_cfg(4'd0, '0, 4'd0, '0, 8'd0, 1'b0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(hd_valid), 64'd0);
    chk("rst_ack", 64'(frame_ack), 64'd0);
    chk("rst_done", 64'(head_done), 64'd0);
    chk("rst_last", 64'(hd_last), 64'd0);
    chk("rst_data", 64'(hd_data), 64'd0);
    chk("rst_cnt", 64'(frame_cnt), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // sync + counter, no padding: EB 90 00 01 then EB 90 00 02
    set_cfg(4'd2, 80'hEB90, 4'd2, 48'h1, 8'd1, 1'b0, 8'h00, 8'd0);
    load_cfg();
    run_frame(0, -1, 0);
    run_frame(0, -1, 0);

    // reserved byte and padding: 7E 05 A5 00 00 00
    set_cfg(4'd1, 80'h7E, 4'd1, 48'h5, 8'd1, 1'b1, 8'hA5, 8'd6);
    load_cfg();
    run_frame(0, -1, 0);

    // backpressure toggling on a 4-byte header, then random stalls
    set_cfg(4'd2, 80'hEB90, 4'd2, 48'h1, 8'd1, 1'b0, 8'h00, 8'd0);
    load_cfg();
    run_frame(1, -1, 0);
    run_frame(2, -1, 0);

    // counter wrap (FE, then 01) and sync length clamp to 10
    set_cfg(4'd12, {$urandom, $urandom, 16'(6'h2A)}, 4'd1, 48'hFE, 8'd3, 1'b0, 8'h00, 8'd0);
    load_cfg();
    run_frame(0, -1, 0);
    run_frame(0, -1, 0);

    // counter length clamp to 6, 48-bit wrap
    set_cfg(4'd0, '0, 4'd9, 48'hFFFF_FFFF_FFFE, 8'd5, 1'b0, 8'h00, 8'd0);
    load_cfg();
    run_frame(0, -1, 0);
    run_frame(0, -1, 0);

    // mid-frame reload: current frame unchanged, next uses 0x10
    set_cfg(4'd2, 80'hEB90, 4'd2, 48'h1, 8'd1, 1'b0, 8'h00, 8'd0);
    load_cfg();
    cntr_init = 48'h10;
    run_frame(0, 2, 0);
    run_frame(0, -1, 0);

    // reload together with request: old value emitted, reload afterwards
    cntr_init = 48'h33;
    run_frame(0, -1, 1);
    run_frame(0, -1, 0);

    // empty header
    set_cfg(4'd0, '0, 4'd0, 48'h7, 8'd2, 1'b0, 8'h00, 8'd0);
    load_cfg();
    run_frame(0, -1, 0);

    // randomized configurations
    for (int t = 0; t < 24; t++) begin
      set_cfg(4'($urandom_range(0, 15)), {16'($urandom), $urandom, $urandom},
              4'($urandom_range(0, 15)), {16'($urandom), $urandom}, 8'($urandom),
              1'($urandom), 8'($urandom), 8'($urandom_range(0, 24)));
      if ($urandom_range(0, 3) == 0) load_cfg();
      run_frame(int'($urandom_range(0, 2)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1,
                1'($urandom_range(0, 5) == 0));
    end

    // reset mid-frame at the second byte
    set_cfg(4'd2, 80'hEB90, 4'd2, 48'h1, 8'd1, 1'b0, 8'h00, 8'd0);
    load_cfg();
    frame_req = 1'b1;
    hd_ready  = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_byte2", 64'(hd_data), 64'h90);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_valid", 64'(hd_valid), 64'd0);
    chk("abort_cnt", 64'(frame_cnt), 64'd0);
    chk("abort_data", 64'(hd_data), 64'd0);
    chk("abort_last", 64'(hd_last), 64'd0);
    chk("abort_done", 64'(head_done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mcnt    = '0;
    mpend   = 1'b0;
    @(negedge clk);
    run_frame(0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_head_seq.md
Name: frame_head_seq

Overview:
- Sequences the frame-header emission for each outgoing frame, using the header configuration held by the header-config latch block.
- Per frame, emits a byte stream in this order: sync code, frame counter, optional reserved byte, then zero padding up to the configured header length.
- Maintains the running 48-bit frame counter, which advances by the configured step after every frame.
- Sits between the header-config latch and the frame assembler; the assembler requests a header, consumes the bytes over a valid/ready stream, then appends the payload.

Parameters:
- SYNC_MAX, 10, maximum number of sync bytes; sync_code_content width is 8*SYNC_MAX.
- CNTR_MAX, 6, maximum number of counter bytes; cntr_init width is 8*CNTR_MAX.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sync_code_length  in  4  number of sync bytes.
- sync_code_content  in  80  sync bytes, right-aligned.
- cntr_length  in  4  number of counter bytes.
- cntr_init  in  48  counter reload value.
- cntr_step  in  8  counter increment per frame.
- res_flag  in  1  when 1, emit the reserved byte.
- res_content  in  8  reserved byte value.
- framehead_len  in  8  minimum total header length in bytes.
- cfg_load  in  1  one-cycle pulse: new config is valid; reload the counter.
- frame_req  in  1  level request for one header.
- frame_ack  out  1  one-cycle pulse: request accepted.
- hd_data  out  8  header byte.
- hd_valid  out  1  hd_data is valid.
- hd_ready  in  1  downstream accepts the byte.
- hd_last  out  1  marks the final header byte.
- head_done  out  1  one-cycle pulse: header complete.
- frame_cnt  out  48  current counter value.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0; internal counter 0; pending-load flag 0.
- States: IDLE, SYNC, CNTR, RES, PAD, FIN.
- Accepting a frame (IDLE with frame_req=1):
  - Snapshot all config inputs and the counter value.
  - Pulse frame_ack for 1 cycle.
  - Move to the first phase with nonzero length, in the order SYNC, CNTR, RES, PAD.
  - hd_valid rises the cycle after frame_ack.
- Lengths:
  - Ls = min(sync_code_length, SYNC_MAX); Lc = min(cntr_length, CNTR_MAX); Lr = res_flag.
  - Lf = Ls + Lc + Lr.
  - PAD emits max(framehead_len − Lf, 0) bytes of 0x00.
  - framehead_len never truncates the fields.
  - Total bytes emitted = max(Lf, framehead_len).
- Byte order:
  - SYNC byte i (i = 0..Ls−1) = sync_code_content[8*(Ls−i)−1 -: 8], MSB first.
  - CNTR byte j = snapshot counter [8*(Lc−j)−1 -: 8], MSB first, low Lc bytes only.
  - RES emits res_content once.
- Stream handshake:
  - A byte transfers when hd_valid and hd_ready are both 1.
  - While hd_ready=0, hd_data, hd_valid and hd_last hold stable.
  - At most 1 byte per cycle; no bubbles between phases when hd_ready stays high.
- hd_last is asserted together with the final byte.
- After the final transfer: enter FIN, pulse head_done for 1 cycle, return to IDLE.
  - A new frame_req can be accepted in the cycle after FIN.
- Empty header (total = 0): frame_ack, then FIN (head_done) on the following cycle; no bytes emitted.
- Counter update at FIN: counter ← counter + cntr_step (zero-extended, 48-bit wrap modulo 2^48).
  - Emitted bytes wrap naturally modulo 2^(8*Lc).
- cfg_load handling:
  - cfg_load in IDLE: counter ← cntr_init next cycle.
  - cfg_load while busy: set the pending flag; the current frame continues on its snapshot. At FIN, counter ← cntr_init (overrides the step) and the pending flag clears.
  - cfg_load and frame_req in the same IDLE cycle: the frame emits the old counter value; the reload is treated as pending.
- frame_cnt always shows the internal counter.
- frame_req dropped mid-frame: ignored; the header completes.
- Reset mid-frame: immediate abort; all outputs return to reset values.

Optional Feature:
- Macro: FRAME_HEAD_CHK_EN.
- When defined:
  - After PAD, a CHK state appends 1 byte equal to the XOR of all previously emitted header bytes.
  - hd_last moves to the CHK byte.
  - Total length = max(Lf, framehead_len) + 1.
  - An empty header emits a single 0x00 byte.
- When undefined: no CHK state; behaviour exactly as above.

Test Plan:
- Sync and counter, no padding: cfg_load with sync len 2, content 0x...EB90, cntr len 2, init 0x0001, step 1, res_flag 0, framehead_len 0; two frames with hd_ready=1 -> bytes EB 90 00 01, then EB 90 00 02; hd_last on the 4th byte; head_done once per frame.
- Reserved byte and padding: sync len 1 (0x7E), cntr len 1 (init 0x05), res_flag 1 (0xA5), framehead_len 6 -> 7E 05 A5 00 00 00.
- Backpressure: toggle hd_ready every cycle during a 4-byte header -> no byte lost or duplicated; outputs stable while stalled.
- Wrap and clamp: cntr len 1, init 0xFE, step 3 -> emits FE, then 01; sync_code_length 12 -> exactly 10 sync bytes.
- Mid-frame cfg_load with init 0x10 -> current frame unchanged; next frame counter = 0x10 (not step-incremented). Reset asserted at byte 2 -> hd_valid=0 immediately; frame_cnt=0.
- With FRAME_HEAD_CHK_EN: bytes EB 90 00 01 -> 5th byte 0x7A with hd_last.
